// File: rtl/ae_pkg.sv
// Shared constants, state encoding and helpers for the arithmetic-encoder
// renormalisation block and its bit accumulator.
package ae_pkg;

  localparam int PREC   = 16;
  localparam int PEND_W = 4;
  localparam int CNT_W  = 5;

  localparam logic [PREC-1:0]   HALF          = 16'h8000;
  localparam logic [PREC-1:0]   QUARTER       = 16'h4000;
  localparam logic [PREC-1:0]   THREE_QUARTER = 16'hC000;
  localparam logic [PEND_W-1:0] PEND_MAX      = '1;
  localparam logic [CNT_W-1:0]  FULL_COUNT    = CNT_W'(PREC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Underflow run length never wraps; it sticks at the largest encodable value.
  function automatic logic [PEND_W-1:0] pend_sat_inc(input logic [PEND_W-1:0] p);
    return (p == PEND_MAX) ? p : p + PEND_W'(1);
  endfunction

endpackage

// File: rtl/ae_bit_accum.sv
// Collects resolved bits MSB-first into a 16-bit word and emits it when full,
// when an underflow run must follow it, or when the encoder flushes.
module ae_bit_accum
  import ae_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_bit,
  input  logic              i_force,
  input  logic [PEND_W-1:0] i_pending,
  output logic [PREC-1:0]   o_bits,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_bits_valid,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_pending_valid
);

  logic [PREC-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [PREC-1:0]  w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_has_pend;
  logic             w_emit;

  // Oldest bit drifts upward, so the word stays right-aligned with zeros above.
  always_comb begin
    w_acc_next = (r_acc << 1) | PREC'(i_bit);
    w_cnt_next = r_cnt + CNT_W'(1);
    w_has_pend = (i_pending != '0);
    w_emit     = i_push && (i_force || w_has_pend || (w_cnt_next == FULL_COUNT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc           <= '0;
      r_cnt           <= '0;
      o_bits          <= '0;
      o_count         <= '0;
      o_bits_valid    <= 1'b0;
      o_pending       <= '0;
      o_pending_valid <= 1'b0;
    end else begin
      o_bits          <= '0;
      o_count         <= '0;
      o_bits_valid    <= 1'b0;
      o_pending       <= '0;
      o_pending_valid <= 1'b0;
      if (w_emit) begin
        o_bits          <= w_acc_next;
        o_count         <= w_cnt_next;
        o_bits_valid    <= 1'b1;
        o_pending       <= i_pending;
        o_pending_valid <= w_has_pend;
        r_acc           <= '0;
        r_cnt           <= '0;
      end else if (i_push) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end
    end
  end

endmodule

// File: rtl/ae_renorm.sv
// Interval renormalisation for a 16-bit binary arithmetic encoder: one E1/E2/E3
// step per cycle, resolved bits handed to ae_bit_accum, end-of-stream flush.
module ae_renorm
  import ae_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] low_in,
  input  logic [15:0] high_in,
  input  logic        sym_valid,
  input  logic        finish,
  output logic        sym_ready,
  output logic [15:0] low_out,
  output logic [15:0] high_out,
  output logic        range_valid,
  output logic [15:0] bits_out,
  output logic [4:0]  bits_count_out,
  output logic        bits_valid,
  output logic [3:0]  pending_bits_out,
  output logic        pending_valid,
  output logic        done,
  output logic        pend_ovf
);

  state_t r_state;
  state_t w_next_state;

  logic [PREC-1:0]   r_low;
  logic [PREC-1:0]   r_high;
  logic [PEND_W-1:0] r_pending;
  logic              r_pend_ovf;
  logic              r_sym_ready;
  logic [PREC-1:0]   r_low_out;
  logic [PREC-1:0]   r_high_out;
  logic              r_range_valid;
  logic              r_done;

  logic              w_accept;
  logic              w_is_e1;
  logic              w_is_e2;
  logic              w_is_e3;
  logic              w_rule;
  logic [PREC-1:0]   w_low_sub;
  logic [PREC-1:0]   w_high_sub;
  logic [PREC-1:0]   w_low_step;
  logic [PREC-1:0]   w_high_step;

  logic              w_push;
  logic              w_bit;
  logic              w_force;
  logic [PEND_W-1:0] w_pend_to_accum;
  logic              w_range_pulse;
  logic              w_done_pulse;

  // sym_ready is registered so it stays low for the first cycle after reset.
  assign w_accept = (r_state == ST_IDLE) && r_sym_ready && sym_valid;

  // E1 takes precedence over E2, E2 over E3.
  always_comb begin
    w_is_e1     = (r_high < HALF);
    w_is_e2     = !w_is_e1 && (r_low >= HALF);
    w_is_e3     = !w_is_e1 && !w_is_e2 && (r_low >= QUARTER) && (r_high < THREE_QUARTER);
    w_rule      = w_is_e1 || w_is_e2 || w_is_e3;
    w_low_sub   = r_low;
    w_high_sub  = r_high;
    if (w_is_e2) begin
      w_low_sub  = r_low - HALF;
      w_high_sub = r_high - HALF;
    end else if (w_is_e3) begin
      w_low_sub  = r_low - QUARTER;
      w_high_sub = r_high - QUARTER;
    end
    w_low_step  = w_low_sub << 1;
    w_high_step = (w_high_sub << 1) | PREC'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)                    w_next_state = ST_SHIFT;
        else if (r_sym_ready && finish)  w_next_state = ST_FLUSH;
      end
      ST_SHIFT: if (!w_rule) w_next_state = ST_IDLE;
      ST_FLUSH: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_push          = 1'b0;
    w_bit           = 1'b0;
    w_force         = 1'b0;
    w_pend_to_accum = '0;
    w_range_pulse   = 1'b0;
    w_done_pulse    = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        w_push          = w_is_e1 || w_is_e2;
        w_bit           = w_is_e2;
        w_pend_to_accum = w_push ? r_pending : '0;
        w_range_pulse   = !w_rule;
      end
      ST_FLUSH: begin
        w_push          = 1'b1;
        w_force         = 1'b1;
        w_bit           = (r_low >= QUARTER);
        w_pend_to_accum = pend_sat_inc(r_pending);
      end
      ST_DONE:  w_done_pulse = 1'b1;
      default:  w_done_pulse = 1'b0;
    endcase
  end

  // Resolving a bit always drains the pending run: emitted with it or already zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_low         <= '0;
      r_high        <= '0;
      r_pending     <= '0;
      r_pend_ovf    <= 1'b0;
      r_sym_ready   <= 1'b0;
      r_low_out     <= '0;
      r_high_out    <= '0;
      r_range_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_sym_ready   <= (w_next_state == ST_IDLE);
      r_range_valid <= w_range_pulse;
      r_done        <= w_done_pulse;
      if (w_accept) begin
        r_low  <= low_in;
        r_high <= high_in;
      end else if ((r_state == ST_SHIFT) && w_rule) begin
        r_low  <= w_low_step;
        r_high <= w_high_step;
      end
      if (w_range_pulse) begin
        r_low_out  <= r_low;
        r_high_out <= r_high;
      end
      if (r_state == ST_FLUSH) begin
        r_pending <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (w_is_e3) begin
          r_pending <= pend_sat_inc(r_pending);
          if (r_pending == PEND_MAX) r_pend_ovf <= 1'b1;
        end else if (w_push) begin
          r_pending <= '0;
        end
      end
      if (r_state == ST_DONE) r_pend_ovf <= 1'b0;
    end
  end

  ae_bit_accum u_accum (
    .clk             (clk),
    .rst             (rst),
    .i_push          (w_push),
    .i_bit           (w_bit),
    .i_force         (w_force),
    .i_pending       (w_pend_to_accum),
    .o_bits          (bits_out),
    .o_count         (bits_count_out),
    .o_bits_valid    (bits_valid),
    .o_pending       (pending_bits_out),
    .o_pending_valid (pending_valid)
  );

  assign sym_ready   = r_sym_ready;
  assign low_out     = r_low_out;
  assign high_out    = r_high_out;
  assign range_valid = r_range_valid;
  assign done        = r_done;
  assign pend_ovf    = r_pend_ovf;

endmodule

// File: doc/ae_renorm.md
AE_RENORM -- requirements
Module: ae_renorm

Interface
REQ-001 Parameters: none; precision fixed at 16 bits; constants come from the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 low_in  input  16  interval low bound after the encoder's interval update.
REQ-005 high_in  input  16  interval high bound after the encoder's interval update.
REQ-006 sym_valid  input  1  low_in/high_in valid; accepted when sym_ready=1.
REQ-007 finish  input  1  end-of-stream request; level, held until done.
REQ-008 sym_ready  output  1  block is IDLE and can accept a symbol or finish.
REQ-009 low_out, high_out  output  16 each  renormalised interval, valid with range_valid.
REQ-010 range_valid  output  1  one-cycle pulse; renormalisation of the accepted symbol complete.
REQ-011 bits_out  output  16  resolved bits, right-aligned; oldest bit at bits_out[bits_count_out-1]; bits above the count are 0.
REQ-012 bits_count_out  output  5  number of valid bits, 1..16.
REQ-013 bits_valid  output  1  one-cycle pulse; no backpressure, downstream always accepts.
REQ-014 pending_bits_out  output  4  underflow run length to append after bits_out: copies of the inverse of the last bit.
REQ-015 pending_valid  output  1  asserted only together with bits_valid when pending_bits_out>0.
REQ-016 done  output  1  one-cycle pulse; finish flush complete.
REQ-017 pend_ovf  output  1  sticky flag: pending counter saturated.

Function
REQ-018 States: IDLE, SHIFT, FLUSH, DONE.
REQ-019 In IDLE: sym_ready=1.
- sym_valid=1 -> latch low/high, go to SHIFT.
- Else finish=1 -> go to FLUSH.
- sym_valid has priority over finish.
REQ-020 SHIFT performs exactly one step per cycle, using HALF=0x8000 and QUARTER=0x4000.
- E1, high<HALF: resolve bit 0.
- E2, low>=HALF: resolve bit 1; subtract HALF from both bounds first.
- E3, low>=QUARTER and high<0xC000: pending+1; subtract QUARTER from both bounds first.
- Each step then applies low<<=1 and high=(high<<1)|1, 16-bit truncated.
REQ-021 When no rule applies in SHIFT: present low_out/high_out, pulse range_valid, return to IDLE; no step is performed that cycle.
- Latency is n+1 cycles after the acceptance edge for n steps; n=0 gives 1 cycle.
REQ-022 A resolved bit is appended to a 16-bit accumulator.
- If pending>0 before the append: emit the accumulator that cycle with pending_bits_out=pending and pending_valid=1, then clear pending.
- Otherwise emit only when the accumulator count reaches 16.
- After any emit the accumulator count is 0.
REQ-023 The accumulator persists across symbols; a partial accumulator is never emitted except by FLUSH.
REQ-024 The pending counter saturates at 15; an E3 step at 15 sets pend_ovf and the counter stays at 15.
REQ-025 FLUSH (one cycle):
- pending+1, saturating.
- Final bit = 0 if latched low<QUARTER, else 1.
- Append the final bit, emit the accumulator (count>=1) with pending if pending>0.
- Clear the accumulator and pending, go to DONE.
REQ-026 DONE: pulse done for one cycle, return to IDLE; pend_ovf clears here.
REQ-027 Outputs other than low_out/high_out are 0 whenever their valid strobe is low.

Reset
REQ-028 Asynchronous rst forces IDLE and clears the accumulator, counts, pending and pend_ovf.
- All outputs go to 0; sym_ready=1 one cycle after release.
REQ-029 Reset mid-SHIFT or mid-FLUSH discards all partial bits; no bits_valid follows.

Structure
REQ-030 Package ae_pkg holds: PREC=16, HALF, QUARTER, THREE_QUARTER, the state enum, and the pending width (4).
REQ-031 One sub-module, ae_bit_accum: accumulator plus emit logic; the FSM stays in ae_renorm.

Verification
REQ-032 low=0x1000, high=0x2FFF -> E1 x2, then E3 x1 (pending=1), then stop.
- low_out=0x0000, high_out=0xFFFF.
- range_valid 4 cycles after acceptance; 2 bits accumulated, no emit.
REQ-033 Following REQ-032, low=0x9000, high=0xFFFF -> E2 resolves 1 with pending=1.
- bits_valid with bits_out=0b001, count=3, pending_bits_out=1, pending_valid=1.
REQ-034 Sixteen single-E1 symbols (low=0x0000, high=0x7FFF) -> exactly one bits_valid: bits_out=0x0000, count=16, pending_valid=0.
REQ-035 Seventeen E3 steps without resolution -> pend_ovf=1; pending_bits_out=15 at the next emit.
REQ-036 finish with low=0x4000, pending=0, accumulator empty -> FLUSH emits bits_out=1, count=1, pending_bits_out=1; done one cycle later.
REQ-037 Assert rst during SHIFT -> all outputs 0, no bits_valid afterwards; the next symbol is processed from an empty accumulator.
